// File: rtl/accel_query_host_pkg.sv
// Shared types and constants for the accelerometer query host: FSM states,
// UART command bytes, error causes and the axis-to-command mapping.
package accel_query_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_HDR,
    ST_LO,
    ST_HI
  } state_t;

  localparam logic [7:0] CMD_X = 8'h78;
  localparam logic [7:0] CMD_Y = 8'h79;
  localparam logic [7:0] CMD_Z = 8'h7A;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_AXIS = 2'd1;
  localparam logic [1:0] ERR_BAD_HDR  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] AXIS_INVALID = 2'd3;

  function automatic logic [7:0] axis_cmd(input logic [1:0] axis);
    case (axis)
      2'd0:    axis_cmd = CMD_X;
      2'd1:    axis_cmd = CMD_Y;
      2'd2:    axis_cmd = CMD_Z;
      default: axis_cmd = '0;
    endcase
  endfunction

endpackage

// File: rtl/accel_query_host_if.sv
// Query/UART/result bundle of accel_query_host. master = environment side
// (requester, UART model), slave = the query host itself.
interface accel_query_host_if;
  logic        req;
  logic [1:0]  axis;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic [15:0] sample;
  logic [1:0]  sample_axis;
  logic        sample_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output req, axis, tx_busy, rx_ready, rx_data,
    input  tx_start, tx_data, sample, sample_axis, sample_valid, err, err_code, busy
  );

  modport slave (
    input  req, axis, tx_busy, rx_ready, rx_data,
    output tx_start, tx_data, sample, sample_axis, sample_valid, err, err_code, busy
  );
endinterface

// File: rtl/accel_query_host_reply_timer.sv
// Reply inactivity timer: counts enabled cycles since the last clear and
// flags expiry on the cycle whose edge completes TIMEOUT_CYCLES counts.
module reply_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i && (count_q != LIMIT))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign expired_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/accel_query_host.sv
// Accelerometer query host: sends an axis command over UART, then collects a
// header byte and a little-endian 16-bit reading. Optional round-robin
// self-polling is enabled by defining ACCEL_QUERY_AUTOPOLL_EN.
module accel_query_host
  import accel_query_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  HDR_BYTE       = 8'h00
) (
  input logic               CLK_50,
  input logic               iRSTN,
  accel_query_host_if.slave bus
);

  state_t      state_q, state_d;
  logic [1:0]  axis_q, axis_d;
  logic [7:0]  lo_q, lo_d;
  logic        seen_busy_q, seen_busy_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] sample_q, sample_d;
  logic [1:0]  sample_axis_q, sample_axis_d;
  logic        sample_valid_q, sample_valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        issue;
  logic [1:0]  issue_axis;
  logic        tx_done, tmr_clear, tmr_en, tmr_expired, timeout_hit;

`ifdef ACCEL_QUERY_AUTOPOLL_EN
  logic [1:0] rr_q, rr_d;
  logic       idle_q;

  // idle_q delays the self-issued query by one IDLE cycle; an explicit req wins.
  always_comb begin
    issue      = (state_q == ST_IDLE) && (bus.req || idle_q);
    issue_axis = bus.req ? bus.axis : rr_q;
    rr_d       = rr_q;
    if (issue && !bus.req)
      rr_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
  end

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      rr_q   <= '0;
      idle_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      idle_q <= (state_q == ST_IDLE);
    end
  end
`else
  assign issue      = (state_q == ST_IDLE) && bus.req;
  assign issue_axis = bus.axis;
`endif

  assign tx_done     = seen_busy_q && !bus.tx_busy;
  assign tmr_en      = (state_q == ST_WAIT_TX) || (state_q == ST_HDR) ||
                       (state_q == ST_LO) || (state_q == ST_HI);
  assign tmr_clear   = bus.rx_ready || ((state_q == ST_SEND) && !bus.tx_busy);
  assign timeout_hit = tmr_expired && !bus.rx_ready;

  reply_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (CLK_50),
    .rst_ni   (iRSTN),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q        <= ST_IDLE;
      axis_q         <= '0;
      lo_q           <= '0;
      seen_busy_q    <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      sample_q       <= '0;
      sample_axis_q  <= '0;
      sample_valid_q <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      axis_q         <= axis_d;
      lo_q           <= lo_d;
      seen_busy_q    <= seen_busy_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      sample_q       <= sample_d;
      sample_axis_q  <= sample_axis_d;
      sample_valid_q <= sample_valid_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (issue && (issue_axis != AXIS_INVALID)) state_d = ST_SEND;
      ST_SEND:    if (!bus.tx_busy) state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_done)          state_d = ST_HDR;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_HDR: begin
        if (bus.rx_ready)     state_d = (bus.rx_data == HDR_BYTE) ? ST_LO : ST_IDLE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_LO: begin
        if (bus.rx_ready)     state_d = ST_HI;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_HI:      if (bus.rx_ready || timeout_hit) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    sample_d       = sample_q;
    sample_axis_d  = sample_axis_q;
    sample_valid_d = 1'b0;
    err_d          = 1'b0;
    err_code_d     = err_code_q;
    axis_d         = axis_q;
    lo_d           = lo_q;
    seen_busy_d    = seen_busy_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (issue_axis == AXIS_INVALID) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_AXIS;
          end else begin
            axis_d = issue_axis;
          end
        end
      end
      ST_SEND: begin
        if (!bus.tx_busy) begin
          tx_start_d  = 1'b1;
          tx_data_d   = axis_cmd(axis_q);
          seen_busy_d = 1'b0;
        end
      end
      ST_WAIT_TX: begin
        if (bus.tx_busy) seen_busy_d = 1'b1;
        if (!tx_done && timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_HDR: begin
        if (bus.rx_ready) begin
          if (bus.rx_data != HDR_BYTE) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_HDR;
          end
        end else if (timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_LO: begin
        if (bus.rx_ready) begin
          lo_d = bus.rx_data;
        end else if (timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_HI: begin
        if (bus.rx_ready) begin
          sample_d       = {bus.rx_data, lo_q};
          sample_axis_d  = axis_q;
          sample_valid_d = 1'b1;
        end else if (timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.sample       = sample_q;
  assign bus.sample_axis  = sample_axis_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.err          = err_q;
  assign bus.err_code     = err_code_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_accel_query_host.sv
// Scoreboard bench for accel_query_host: directed queries push expected
// tx bytes, samples and errors; a negedge monitor pops and compares them.
module tb_accel_query_host;

  typedef struct {
    logic [1:0] code;
    int         at;
  } err_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tx = 0;
  int   n_sv = 0;

  logic [7:0]  q_tx[$];
  logic [17:0] q_smp[$];
  err_exp_t    q_err[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accel_query_host_if bus_if ();

  accel_query_host #(
    .TIMEOUT_CYCLES(100),
    .HDR_BYTE      (8'h00)
  ) dut (
    .CLK_50(clk),
    .iRSTN (rst_n),
    .bus   (bus_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    err_exp_t e;
    if (bus_if.tx_start === 1'b1) begin
      n_tx++;
      if (q_tx.size() == 0) chk("tx_start_unexpected", 32'(bus_if.tx_data), 32'hFFFF_FFFF);
      else                  chk("tx_data", 32'(bus_if.tx_data), 32'(q_tx.pop_front()));
    end
    if (bus_if.sample_valid === 1'b1) begin
      n_sv++;
      if (q_smp.size() == 0) chk("sample_valid_unexpected", 32'({bus_if.sample_axis, bus_if.sample}), 32'hFFFF_FFFF);
      else                   chk("sample_axis_value", 32'({bus_if.sample_axis, bus_if.sample}), 32'(q_smp.pop_front()));
    end
    if (bus_if.err === 1'b1) begin
      if (q_err.size() == 0) chk("err_unexpected", 32'(bus_if.err_code), 32'hFFFF_FFFF);
      else begin
        e = q_err.pop_front();
        chk("err_code", 32'(bus_if.err_code), 32'(e.code));
        if (e.at >= 0) chk("err_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic pulse_req(input logic [1:0] a);
    @(negedge clk);
    bus_if.req  = 1'b1;
    bus_if.axis = a;
    @(negedge clk);
    bus_if.req  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_if.rx_ready = 1'b1;
    bus_if.rx_data  = b;
    @(negedge clk);
    bus_if.rx_ready = 1'b0;
    bus_if.rx_data  = '0;
    repeat (3) @(negedge clk);
  endtask

  // UART model: wait (bounded) for tx_start, then hold tx_busy for busy_len cycles.
  task automatic uart_ack(input int busy_len, output int waited);
    waited = 0;
    while (waited < 100) begin
      @(negedge clk);
      waited++;
      if (bus_if.tx_start === 1'b1) break;
    end
    chk("tx_start_seen", 32'(bus_if.tx_start), 32'd1);
    bus_if.tx_busy = 1'b1;
    repeat (busy_len) @(negedge clk);
    bus_if.tx_busy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((bus_if.busy !== 1'b0) && (k < 300)) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(bus_if.busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_start"},     32'(bus_if.tx_start),     32'd0);
    chk({tag, "_tx_data"},      32'(bus_if.tx_data),      32'd0);
    chk({tag, "_sample"},       32'(bus_if.sample),       32'd0);
    chk({tag, "_sample_axis"},  32'(bus_if.sample_axis),  32'd0);
    chk({tag, "_sample_valid"}, 32'(bus_if.sample_valid), 32'd0);
    chk({tag, "_err"},          32'(bus_if.err),          32'd0);
    chk({tag, "_err_code"},     32'(bus_if.err_code),     32'd0);
    chk({tag, "_busy"},         32'(bus_if.busy),         32'd0);
  endtask

  initial begin
    #400us;
    $display("FAIL global_timeout: actual=running required=finished (cycle %0d)", cyc);
    $fatal(1, "bench watchdog");
  end

  initial begin
    int w, tx0, sv0;
    rst_n           = 1'b0;
    bus_if.req      = 1'b0;
    bus_if.axis     = '0;
    bus_if.tx_busy  = 1'b0;
    bus_if.rx_ready = 1'b0;
    bus_if.rx_data  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_after_reset", 32'(bus_if.busy), 32'd0);

    // Good query on y: reply 00,34,12 -> 16'h1234.
    tx0 = n_tx; sv0 = n_sv;
    q_tx.push_back(8'h79);
    q_smp.push_back({2'd1, 16'h1234});
    pulse_req(2'd1);
    uart_ack(4, w);
    send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
    wait_idle("t1_idle");
    repeat (2) @(negedge clk);
    chk("t1_tx_count", 32'(n_tx - tx0), 32'd1);
    chk("t1_sv_count", 32'(n_sv - sv0), 32'd1);
    chk("t1_sample", 32'(bus_if.sample), 32'h1234);
    chk("t1_sample_axis", 32'(bus_if.sample_axis), 32'd1);

    // Invalid axis: err code 1 on the next cycle, no transmit, never busy.
    tx0 = n_tx;
    @(negedge clk);
    q_err.push_back('{2'd1, cyc + 1});
    bus_if.req  = 1'b1;
    bus_if.axis = 2'd3;
    @(negedge clk);
    bus_if.req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_busy_low", 32'(bus_if.busy), 32'd0);
      @(negedge clk);
    end
    chk("t2_no_tx", 32'(n_tx - tx0), 32'd0);

    // Bad header on x: err code 2, stray byte dropped, sample kept.
    sv0 = n_sv;
    q_tx.push_back(8'h78);
    q_err.push_back('{2'd2, -1});
    pulse_req(2'd0);
    uart_ack(4, w);
    send_byte(8'h55); send_byte(8'h66);
    wait_idle("t3_idle");
    chk("t3_sample_kept", 32'(bus_if.sample), 32'h1234);
    chk("t3_axis_kept", 32'(bus_if.sample_axis), 32'd1);
    chk("t3_no_sample", 32'(n_sv - sv0), 32'd0);

    // Header only on z: timeout 100 cycles after the header strobe.
    q_tx.push_back(8'h7A);
    pulse_req(2'd2);
    uart_ack(4, w);
    @(negedge clk);
    q_err.push_back('{2'd3, cyc + 101});
    bus_if.rx_ready = 1'b1;
    bus_if.rx_data  = 8'h00;
    @(negedge clk);
    bus_if.rx_ready = 1'b0;
    wait_idle("t4_idle");
    repeat (2) @(negedge clk);
    chk("t4_sample_kept", 32'(bus_if.sample), 32'h1234);

    // tx_busy held 50 cycles: start only after it falls; second req ignored.
    tx0 = n_tx; sv0 = n_sv;
    @(negedge clk);
    bus_if.tx_busy = 1'b1;
    q_tx.push_back(8'h78);
    q_smp.push_back({2'd0, 16'hABCD});
    pulse_req(2'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) begin bus_if.req = 1'b1; bus_if.axis = 2'd2; end
      if (i == 11) bus_if.req = 1'b0;
    end
    chk("t5_busy_held", 32'(bus_if.busy), 32'd1);
    chk("t5_no_tx_while_busy", 32'(n_tx - tx0), 32'd0);
    bus_if.tx_busy = 1'b0;
    uart_ack(4, w);
    chk("t5_tx_after_fall", 32'(w), 32'd1);
    send_byte(8'h00); send_byte(8'hCD); send_byte(8'hAB);
    wait_idle("t5_idle");
    repeat (2) @(negedge clk);
    chk("t5_tx_count", 32'(n_tx - tx0), 32'd1);
    chk("t5_sv_count", 32'(n_sv - sv0), 32'd1);
    chk("t5_sample", 32'(bus_if.sample), 32'hABCD);
    chk("t5_sample_axis", 32'(bus_if.sample_axis), 32'd0);

    // Reset after the low byte: outputs clear at once, later HI byte dropped.
    sv0 = n_sv;
    q_tx.push_back(8'h79);
    pulse_req(2'd1);
    uart_ack(4, w);
    send_byte(8'h00); send_byte(8'h11);
    chk("t6_busy_before_reset", 32'(bus_if.busy), 32'd1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h22);
    repeat (3) @(negedge clk);
    chk("t6_sample_zero", 32'(bus_if.sample), 32'd0);
    chk("t6_busy_zero", 32'(bus_if.busy), 32'd0);
    chk("t6_no_sample", 32'(n_sv - sv0), 32'd0);

    chk("drain_tx", 32'(q_tx.size()), 32'd0);
    chk("drain_sample", 32'(q_smp.size()), 32'd0);
    chk("drain_err", 32'(q_err.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accel_query_host.md
ACCEL_QUERY_HOST -- requirements
Module: accel_query_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, meaning the reply inactivity limit in CLK_50 cycles (50 ms).
REQ-002 SHALL have parameter HDR_BYTE, default 8'h00, meaning the expected first reply byte.
REQ-003 SHALL have port CLK_50, input, 1, the single system clock (50 MHz).
REQ-004 SHALL have port iRSTN, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port req, input, 1, a one-cycle query request.
REQ-006 SHALL have port axis, input, 2, the axis select (0=x, 1=y, 2=z, 3=invalid), sampled when req is accepted.
REQ-007 SHALL have port tx_start, output, 1, the UART transmitter start strobe.
REQ-008 SHALL have port tx_data, output, 8, the command byte to the UART transmitter.
REQ-009 SHALL have port tx_busy, input, 1, the UART transmitter busy flag.
REQ-010 SHALL have port rx_ready, input, 1, a one-cycle received-byte strobe.
REQ-011 SHALL have port rx_data, input, 8, the received byte, valid while rx_ready is high.
REQ-012 SHALL have port sample, output, 16, the last assembled reading as {hi, lo}.
REQ-013 SHALL have port sample_axis, output, 2, the axis of the last sample.
REQ-014 SHALL have port sample_valid, output, 1, a one-cycle pulse when a new sample is stored.
REQ-015 SHALL have port err, output, 1, a one-cycle pulse on a failed query.
REQ-016 SHALL have port err_code, output, 2, the failure cause (1=bad axis, 2=bad header, 3=timeout).
REQ-017 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, SEND, WAIT_TX, HDR, LO, HI, which are transition-driven only.
REQ-019 IDLE: SHALL accept req and go to SEND; if axis==3, SHALL pulse err with err_code=1 in the next cycle and stay in IDLE.
REQ-020 SEND: SHALL wait until tx_busy=0, then drive tx_start=1 for exactly one cycle with tx_data set to 8'h78/8'h79/8'h7A for axis 0/1/2, then go to WAIT_TX.
REQ-021 WAIT_TX: SHALL wait for tx_busy to rise and then fall, then go to HDR.
REQ-022 HDR: on rx_ready, if rx_data==HDR_BYTE go to LO; otherwise pulse err with err_code=2 and return to IDLE.
REQ-023 LO: on rx_ready, SHALL store rx_data as the low byte and go to HI.
REQ-024 HI: on rx_ready, SHALL update sample={rx_data, lo} and sample_axis, and pulse sample_valid in the cycle after the strobe; then go to IDLE.
REQ-025 SHALL apply a timeout: the counter clears on entry to WAIT_TX and on every rx_ready, and counts in WAIT_TX/HDR/LO/HI; reaching TIMEOUT_CYCLES SHALL pulse err with err_code=3 and return to IDLE.
REQ-026 SHALL ignore req while busy=1 (no queueing).
REQ-027 SHALL ignore rx_ready in IDLE, SEND and WAIT_TX (stray bytes are dropped).
REQ-028 If timeout and rx_ready coincide, rx_ready SHALL win and the counter SHALL clear.
REQ-029 sample and sample_axis SHALL hold their values on error (the last good reading is kept).
REQ-030 Query latency from req to sample_valid SHALL be 1 + TX wait + 4 UART byte times + 1 cycle.

Reset
REQ-031 iRSTN low SHALL asynchronously force IDLE, tx_start=0, tx_data=0, sample=0, sample_axis=0, sample_valid=0, err=0, err_code=0, busy=0, timer=0.
REQ-032 Reset mid-query SHALL abort the query with no err pulse; bytes arriving after release SHALL be dropped per REQ-027.

Configuration
REQ-033 With ACCEL_QUERY_AUTOPOLL_EN defined, the block SHALL self-issue queries from IDLE in round-robin x→y→z→x, starting at x after reset, one cycle after returning to IDLE; req is still honoured and preempts the round-robin choice.
REQ-034 Without ACCEL_QUERY_AUTOPOLL_EN, queries SHALL start only on req.

Structure
REQ-035 Package accel_query_pkg SHALL hold the state enum, the command byte constants (8'h78, 8'h79, 8'h7A), and the err_code constants.
REQ-036 The timeout SHALL be implemented in sub-module reply_timer (clear, enable, expired), with its width derived from TIMEOUT_CYCLES.

Verification
REQ-037 The bench SHALL cover: req, axis=1; reply 00,34,12 -> tx_data=8'h79 with one tx_start, sample=16'h1234, sample_axis=1, one sample_valid.
REQ-038 The bench SHALL cover: req, axis=3 -> err_code=1, no tx_start, busy stays 0.
REQ-039 The bench SHALL cover: req, axis=0; reply 55,.. -> err_code=2, sample unchanged.
REQ-040 The bench SHALL cover: TIMEOUT_CYCLES=100; req, axis=2; reply 00 only -> err_code=3, 100 cycles after the header.
REQ-041 The bench SHALL cover: tx_busy held high 50 cycles at req -> tx_start asserts only after tx_busy falls; a second req while busy is ignored.
REQ-042 The bench SHALL cover: iRSTN asserted after the LO byte -> all outputs are zero at once, and the following HI byte is ignored.
